// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit (MUL, MULH, DIVU, REMU) with fixed latency
// and direct register-file writeback on completion.
module mul_div_unit #(
  parameter int unsigned DW   = 19,
  parameter int unsigned AW   = 4,
  parameter int unsigned ITER = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [AW-1:0] dest,
  output logic          busy,
  output logic          done,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  localparam int unsigned CW = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] count;
  logic [1:0]    op_q;
  logic [AW-1:0] dest_q;
  logic [DW-1:0] opnd;     // multiplicand or divisor
  logic [DW:0]   hi;       // product upper half or partial remainder
  logic [DW-1:0] lo;       // multiplier shifting out / dividend shifting into quotient

  logic [DW:0]   hi_next;
  logic [DW-1:0] lo_next;
  logic [DW:0]   mul_add;
  logic [DW:0]   mul_sum;
  logic [DW+1:0] div_sh;
  logic [DW+1:0] div_diff;
  logic [DW-1:0] result;
  logic          last;

  // One shift-add or restoring-divide step on the current datapath registers
  always_comb begin
    hi_next  = hi;
    lo_next  = lo;
    mul_add  = lo[0] ? {1'b0, opnd} : '0;
    mul_sum  = {1'b0, hi[DW-1:0]} + mul_add;
    div_sh   = {hi, lo[DW-1]};
    div_diff = div_sh - {2'b00, opnd};
    if (!op_q[1]) begin
      hi_next = {1'b0, mul_sum[DW:1]};
      lo_next = {mul_sum[0], lo[DW-1:1]};
    end else if (!div_diff[DW+1]) begin
      hi_next = div_diff[DW:0];
      lo_next = {lo[DW-2:0], 1'b1};
    end else begin
      hi_next = div_sh[DW:0];
      lo_next = {lo[DW-2:0], 1'b0};
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:  result = lo_next;
      OP_MULH: result = hi_next[DW-1:0];
      OP_DIVU: result = lo_next;
      OP_REMU: result = hi_next[DW-1:0];
      default: result = '0;
    endcase
  end

  assign last = (count == CW'(ITER - 1));

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_BUSY;
      S_BUSY:  if (last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath and registered writeback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      busy    <= (state_next != S_IDLE);
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest;
            opnd   <= opb;
            hi     <= '0;
            lo     <= opa;
            count  <= '0;
          end
        end
        S_BUSY: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + CW'(1);
          if (last) begin
            done    <= 1'b1;
            wb_en   <= (dest_q != '0);
            wb_addr <= dest_q;
            wb_data <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected writebacks queued at launch, checked on done.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [18:0] opa;
  logic [18:0] opb;
  logic [3:0]  dest;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [18:0] wb_data;

  typedef struct {
    logic [3:0]  addr;
    logic [18:0] data;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0    = 0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .dest(dest), .busy(busy), .done(done), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] model(input logic [1:0] o, input logic [18:0] a,
                                        input logic [18:0] b);
    logic [37:0] p;
    p = {19'd0, a} * {19'd0, b};
    case (o)
      2'b00:   return p[18:0];
      2'b01:   return p[37:19];
      2'b10:   return (b == 0) ? 19'h7FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called just after a negedge; start is sampled at the next posedge (E0)
  task automatic launch(input logic [1:0] o, input logic [18:0] a, input logic [18:0] b,
                        input logic [3:0] d, input logic [18:0] r);
    exp_t e;
    op = o; opa = a; opb = b; dest = d; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    op = 2'($urandom); opa = 19'($urandom); opb = 19'($urandom); dest = 4'($urandom);
    e.addr = d; e.data = r; e.wen = (d != 0);
    sb.push_back(e);
  endtask

  task automatic wait_result(input string name);
    int   n = 0;
    bit   found = 0;
    exp_t e;
    while (n < 40 && !found) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("FAIL %s busy: got %b want 1", name, busy);
        end
      end
      if (done === 1'b1) found = 1;
    end
    if (sb.size() == 0) begin
      total++; bad++; $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (!found) begin
      bad++; $display("FAIL %s timeout: got no done want done", name);
      return;
    end
    total++;
    if (cyc - e0 != 19) begin
      bad++; $display("FAIL %s latency: got %0d want 19", name, cyc - e0);
    end
    total++;
    if (wb_en !== e.wen) begin
      bad++; $display("FAIL %s wb_en: got %b want %b", name, wb_en, e.wen);
    end
    total++;
    if (wb_addr !== e.addr) begin
      bad++; $display("FAIL %s wb_addr: got %0d want %0d", name, wb_addr, e.addr);
    end
    total++;
    if (wb_data !== e.data) begin
      bad++; $display("FAIL %s wb_data: got %05h want %05h", name, wb_data, e.data);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 19'd0) begin
      bad++;
      $display("FAIL %s idle: got busy=%b done=%b wb_en=%b addr=%0d data=%05h want all 0",
               name, busy, done, wb_en, wb_addr, wb_data);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || wb_en !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL %s extra result: got %0d done cycles want 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0; dest = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    launch(2'b00, 19'd3, 19'd5, 4'd2, 19'd15);
    wait_result("mul_3x5");
    check_idle("mul_3x5");
    launch(2'b01, 19'h7FFFF, 19'h7FFFF, 4'd4, 19'h7FFFE);
    wait_result("mulh_max");
    check_idle("mulh_max");
    launch(2'b00, 19'h7FFFF, 19'h7FFFF, 4'd4, 19'h00001);
    wait_result("mul_max");
    check_idle("mul_max");
  endtask

  task automatic test_div();
    launch(2'b10, 19'd100, 19'd7, 4'd6, 19'd14);
    wait_result("divu_100_7");
    check_idle("divu_100_7");
    launch(2'b11, 19'd100, 19'd7, 4'd7, 19'd2);
    wait_result("remu_100_7");
    check_idle("remu_100_7");
    launch(2'b10, 19'h12345, 19'd0, 4'd8, 19'h7FFFF);
    wait_result("divu_by0");
    check_idle("divu_by0");
    launch(2'b11, 19'h12345, 19'd0, 4'd9, 19'h12345);
    wait_result("remu_by0");
    check_idle("remu_by0");
  endtask

  task automatic test_ignored_start();
    launch(2'b00, 19'd6, 19'd7, 4'd3, 19'd42);
    repeat (5) @(negedge clk);
    op = 2'b10; opa = 19'd9; opb = 19'd3; dest = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored_start");
    @(negedge clk);
    // next start sampled at E21
    launch(2'b00, 19'd11, 19'd13, 4'd1, 19'd143);
    wait_result("start_at_e21");
    check_idle("start_at_e21");
    check_quiet("ignored_start", 25);
  endtask

  task automatic test_reset_mid();
    exp_t dummy;
    launch(2'b10, 19'd1000, 19'd10, 4'd5, 19'd100);
    dummy = sb.pop_back();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got busy=%b done=%b wb_en=%b want 0 0 0", busy, done, wb_en);
    end
    check_quiet("reset_mid", 30);
    launch(2'b10, 19'd1000, 19'd10, 4'd5, 19'd100);
    wait_result("after_reset");
    check_idle("after_reset");
  endtask

  task automatic test_dest_zero();
    launch(2'b00, 19'd2, 19'd2, 4'd0, 19'd4);
    wait_result("dest_zero");
    check_idle("dest_zero");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [18:0] a;
    logic [18:0] b;
    logic [3:0]  d;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i);
      a = 19'($urandom);
      b = (i == 7) ? 19'($urandom_range(1, 15)) : 19'($urandom);
      d = 4'($urandom_range(0, 15));
      launch(o, a, b, d, model(o, a, b));
      wait_result("b2b");
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_ignored_start();
    test_reset_mid();
    test_dest_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative 19-bit multiply/divide unit for the single-cycle CPU. It takes its two operands from the register file read ports (rd_data1, rd_data2) and returns its result to the register file write port (wr_en, wr_addr, wr_data) after a fixed multi-cycle latency. The core stalls on busy while an operation is in flight. The block handles MUL, MULH, DIVU and REMU, which the single-cycle ALU cannot do.

Parameters:
DW, 19, operand/result width; must match register file data width
AW, 4, register address width (16 registers)
ITER, 19, iteration count; equals DW

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL (low DW of product), 01 MULH (high DW of unsigned product), 10 DIVU quotient, 11 REMU remainder
opa  input  DW  operand A / dividend (from rd_data1)
opb  input  DW  operand B / divisor (from rd_data2)
dest  input  AW  destination register
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse, result valid
wb_en  output  1  write enable to register file
wb_addr  output  AW  write address
wb_data  output  DW  write data

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything. Effects: state to IDLE; counter, accumulators and latched op/dest cleared; busy=done=wb_en=0; wb_addr=0; wb_data=0.
- FSM states: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: if start=1 at edge E0, latch op, opa, opb and dest, clear count, and go to BUSY. Otherwise stay in IDLE.
- BUSY: one iteration per edge, E1..E19. Count increments each edge. At the edge where count reaches ITER-1, go to DONE.
- DONE: lasts one cycle, between E19 and E20. In this cycle done=1, wb_data=result and wb_addr=latched dest. wb_en=1 unless dest==0. At E20 go to IDLE.
- Timing summary:
  - busy is registered: high from E0 through E20.
  - The earliest next start is sampled at E21.
  - done is visible 19 cycles after the start edge.
  - Outside DONE: wb_en=0, done=0; wb_data and wb_addr hold 0.
- MUL/MULH algorithm: shift-add over a 2*DW-bit product register, unsigned. Per iteration: if multiplier LSB=1, add multiplicand into the upper half; then shift right by 1 with carry-in. MUL returns product[DW-1:0]; MULH returns product[2DW-1:DW].
- DIVU/REMU algorithm: restoring division over a DW+1-bit partial remainder. Per iteration: shift left, bringing in the next dividend bit MSB-first; trial-subtract the divisor; set the quotient bit to 1 and keep the difference if non-negative, else restore.
- Divide by zero: no special path and no exception. The algorithm naturally yields quotient = all ones (0x7FFFF) and remainder = dividend.
- start asserted in BUSY or DONE is ignored: no latching, no queuing, no effect on the current result. Operand and op input changes after E0 have no effect.
- dest==0: full latency and done pulse, but wb_en stays 0 (r0 is hardwired zero).
- Arithmetic is unsigned, widths are fixed at DW, and there is no overflow flag.

Test Plan:
- MUL: start, op=00, opa=3, opb=5, dest=2 -> done and wb_en high exactly 19 cycles after the start edge, wb_addr=2, wb_data=15; busy low after next edge.
- MULH/MUL corner: opa=opb=0x7FFFF, op=01 -> wb_data=0x7FFFE; same operands with op=00 -> wb_data=0x00001.
- DIVU/REMU: opa=100, opb=7 -> op=10 gives 14; op=11 gives 2. Also opa=0x12345, opb=0 -> op=10 gives 0x7FFFF; op=11 gives 0x12345.
- Ignored start: start op=00, 6*7, dest=3. Pulse start with op=10, opa=9, opb=3 at cycle 5 of BUSY -> single done, wb_data=42, wb_addr=3, no second result. New start at E21 is accepted.
- Reset mid-operation: start DIVU 1000/10, drop rst_n for one edge at cycle 8 -> busy, done and wb_en all 0 the following cycle, no writeback ever issued. A fresh start then completes normally.
- dest=0: MUL 2*2 to dest 0 -> done pulses at 19 cycles with wb_en=0 throughout.
